// File: rtl/mmio_responder_if.sv
// mmio_responder_if
//  Processor data-memory bus as seen by I/O responders.
//  address : word address from processor
//  data    : write data
//  wren    : write strobe, valid with address
//  rden    : read strobe, gates read side effects
//  q       : registered read data (latency 1)
//  hit     : registered, previous-cycle address was inside the responder window
interface mmio_responder_if;
  logic [11:0] address;
  logic [31:0] data;
  logic        wren;
  logic        rden;
  logic [31:0] q;
  logic        hit;

  modport master (output address, data, wren, rden, input q, hit);
  modport slave  (input address, data, wren, rden, output q, hit);
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder
//  16-word I/O window on the data-memory bus: 8-bit key-code FIFO fed by the
//  keyboard receiver, programmable frame-tick timer and LED register.
//  The top level muxes q_dmem with bus.q when bus.hit=1.
// Ports
//  clock      : system clock, all state on rising edge
//  reset      : asynchronous active-low, clears all state
//  bus        : processor bus (slave side), see mmio_responder_if
//  key_valid  : one-cycle push strobe from keyboard receiver
//  key_code   : scancode, valid with key_valid
//  led        : LED register
//  tick_pulse : one-cycle pulse per timer period
// Register map (offset = address[3:0]), unlisted offsets read 0:
//  0 KEY_DATA  RO    {23'b0, nonempty, head}; read pops when nonempty
//  1 KEY_STAT  R/W1C {16'b0, overflow, full, empty, 5'b0, count[7:0]}
//  2 TICK_COUNT R/W  any write clears
//  3 TICK_PER  RW    write also restarts the prescaler
//  4 LED       RW    led = data[9:0]
module mmio_responder #(
  parameter logic [11:0] IO_BASE    = 12'hFF0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TICK_W     = 24
) (
  input  logic              clock,
  input  logic              reset,
  mmio_responder_if.slave   bus,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  output logic [9:0]        led,
  output logic              tick_pulse
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [TICK_W-1:0] tick_period;
  logic [TICK_W-1:0] prescaler;
  logic [31:0]       tick_count;

  logic        in_win, wr_acc, rd_acc;
  logic [3:0]  offset;
  logic        empty, full, pop, push_ok, ovf_set;
  logic        write_per, write_cnt, tick_fire;
  logic [7:0]  count8;
  logic [31:0] rdata;
  logic        unused_data;

  assign in_win  = (bus.address[11:4] == IO_BASE[11:4]);
  assign offset  = bus.address[3:0];
  assign wr_acc  = in_win & bus.wren;
  // write wins over a simultaneous read, so a write never pops
  assign rd_acc  = in_win & bus.rden & ~bus.wren;

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd_acc && (offset == 4'd0) && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok = key_valid && (!full || pop);
  assign ovf_set = key_valid && full && !pop;
  assign count8  = 8'(count);

  assign write_per = wr_acc && (offset == 4'd3);
  assign write_cnt = wr_acc && (offset == 4'd2);
  // a period write restarts the timer, so it also suppresses a tick due that cycle
  assign tick_fire = (tick_period != '0) && (prescaler == tick_period - TICK_W'(1)) && !write_per;

  assign unused_data = ^bus.data;

  // read data is taken from the pre-update state of this cycle
  always_comb begin
    rdata = '0;
    unique case (offset)
      4'd0:    rdata = empty ? '0 : {23'b0, 1'b1, mem[rd_ptr]};
      4'd1:    rdata = {16'b0, overflow, full, empty, 5'b0, count8};
      4'd2:    rdata = tick_count;
      4'd3:    rdata = 32'(tick_period);
      4'd4:    rdata = {22'b0, led};
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.q   <= '0;
      bus.hit <= 1'b0;
      led     <= '0;
    end else begin
      bus.q   <= rd_acc ? rdata : '0;
      bus.hit <= in_win;
      if (wr_acc && (offset == 4'd4)) led <= bus.data[9:0];
    end
  end

  // storage needs no reset: entries are only visible while count says they are valid
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set)
        overflow <= 1'b1;
      else if (wr_acc && (offset == 4'd1) && bus.data[15])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_period <= '0;
      prescaler   <= '0;
      tick_count  <= '0;
      tick_pulse  <= 1'b0;
    end else begin
      tick_pulse <= tick_fire;
      if (write_per) tick_period <= bus.data[TICK_W-1:0];
      if (write_per || tick_period == '0 || tick_fire)
        prescaler <= '0;
      else
        prescaler <= prescaler + TICK_W'(1);
      if (write_cnt)
        tick_count <= '0;
      else if (tick_fire)
        tick_count <= tick_count + 32'd1;
    end
  end

endmodule
